// File: rtl/ex_stage_if.sv
// ex_stage_if: the bundle between decode, the DLX execute stage and the MEM stage.
// Buses use [0:N] numbering with bit 0 as the MSB, as in the rest of the pipeline.
//
// Handshake: there is no valid/ready pair. An instruction is presented on the
// *_in signals with stall_in=0. The execute stage accepts it on a rising edge
// whenever its multiply/divide unit is idle. While hold_out=1, decode must keep
// every *_in signal stable. The held instruction is accepted on the first edge
// after hold_out has fallen. stall_out=1 marks the MEM-side outputs as a bubble.
//
// modport master : decode/MEM side (drives *_in, observes *_out)
// modport slave  : execute stage  (observes *_in, drives *_out)
interface ex_stage_if;
  logic [0:5]  op_in;
  logic [0:5]  fc_in;
  logic [0:31] a_in;
  logic [0:31] b_in;
  logic [0:31] imm_in;
  logic [0:31] npc_in;
  logic [0:4]  dreg_in;
  logic        stall_in;
  logic [0:31] alu_data_out;
  logic [0:31] mdr_out;
  logic        cond_out;
  logic [0:5]  op_out;
  logic [0:5]  fc_out;
  logic [0:4]  dreg_out;
  logic        stall_out;
  logic        hold_out;

  modport master (
    output op_in, fc_in, a_in, b_in, imm_in, npc_in, dreg_in, stall_in,
    input  alu_data_out, mdr_out, cond_out, op_out, fc_out, dreg_out,
           stall_out, hold_out
  );

  modport slave (
    input  op_in, fc_in, a_in, b_in, imm_in, npc_in, dreg_in, stall_in,
    output alu_data_out, mdr_out, cond_out, op_out, fc_out, dreg_out,
           stall_out, hold_out
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: DLX execute stage. Every MEM-stage input is registered here.
// A single-cycle ALU handles arithmetic, logic, shifts, compares, LHI, address
// generation and branch resolution. MULT and DIV use an iterative unit that
// retires one bit per clock and asks decode to hold while it is busy.
//
// Ports:
//   clock        stage clock; outputs update on the rising edge
//   reset_n      asynchronous, active-low reset
//   bus          ex_stage_if.slave (decode inputs, MEM outputs, hold_out)
//   o_dbg_state  current multiply/divide FSM state (0 idle, 1 mul, 2 div)
module ex_stage #(
  parameter int          MD_ITERS    = 32,
  parameter logic [31:0] DIVZ_RESULT = 32'hFFFF_FFFF
) (
  input  logic       clock,
  input  logic       reset_n,
  ex_stage_if.slave  bus,
  output logic [1:0] o_dbg_state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQZ  = 6'b000100;
  localparam logic [5:0] OP_BNEZ  = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDUI = 6'b001001;
  localparam logic [5:0] OP_SUBI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LHI   = 6'b001111;

  localparam logic [5:0] FC_SLL  = 6'b000100;
  localparam logic [5:0] FC_SRL  = 6'b000110;
  localparam logic [5:0] FC_SRA  = 6'b000111;
  localparam logic [5:0] FC_MULT = 6'b001110;
  localparam logic [5:0] FC_DIV  = 6'b001111;
  localparam logic [5:0] FC_ADD  = 6'b100000;
  localparam logic [5:0] FC_ADDU = 6'b100001;
  localparam logic [5:0] FC_SUB  = 6'b100010;
  localparam logic [5:0] FC_SUBU = 6'b100011;
  localparam logic [5:0] FC_AND  = 6'b100100;
  localparam logic [5:0] FC_OR   = 6'b100101;
  localparam logic [5:0] FC_XOR  = 6'b100110;
  localparam logic [5:0] FC_SEQ  = 6'b101000;
  localparam logic [5:0] FC_SNE  = 6'b101001;
  localparam logic [5:0] FC_SLT  = 6'b101010;
  localparam logic [5:0] FC_SGT  = 6'b101011;
  localparam logic [5:0] FC_SLE  = 6'b101100;
  localparam logic [5:0] FC_SGE  = 6'b101101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  // MUL: r_acc = partial product, r_mcand = a shifted left, r_mplier = b shifted right.
  // DIV: r_acc = remainder, r_mcand = divisor, r_mplier = dividend shifting into quotient.
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;

  logic [31:0] r_alu;
  logic [31:0] r_mdr;
  logic        r_cond;
  logic [5:0]  r_op;
  logic [5:0]  r_fc;
  logic [4:0]  r_dreg;
  logic        r_stall;
  logic        r_hold;

  // Re-ranged views of the [0:N] bus so arithmetic reads naturally.
  logic [5:0]  w_op;
  logic [5:0]  w_fc;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_imm;
  logic [31:0] w_npc;
  logic [4:0]  w_sh;

  assign w_op  = bus.op_in;
  assign w_fc  = bus.fc_in;
  assign w_a   = bus.a_in;
  assign w_b   = bus.b_in;
  assign w_imm = bus.imm_in;
  assign w_npc = bus.npc_in;
  assign w_sh  = bus.b_in[27:31];

  logic [31:0] w_res;
  logic        w_cond;
  logic        w_is_md;

  assign w_is_md = (w_op == OP_RTYPE) && ((w_fc == FC_MULT) || (w_fc == FC_DIV));

  always_comb begin
    w_res  = w_a + w_imm;
    w_cond = 1'b0;
    casez (w_op)
      OP_RTYPE: begin
        case (w_fc)
          FC_ADD, FC_ADDU: w_res = w_a + w_b;
          FC_SUB, FC_SUBU: w_res = w_a - w_b;
          FC_AND:          w_res = w_a & w_b;
          FC_OR:           w_res = w_a | w_b;
          FC_XOR:          w_res = w_a ^ w_b;
          FC_SLL:          w_res = w_a << w_sh;
          FC_SRL:          w_res = w_a >> w_sh;
          FC_SRA:          w_res = $signed(w_a) >>> w_sh;
          FC_SEQ:          w_res = {31'd0, w_a == w_b};
          FC_SNE:          w_res = {31'd0, w_a != w_b};
          FC_SLT:          w_res = {31'd0, $signed(w_a) <  $signed(w_b)};
          FC_SGT:          w_res = {31'd0, $signed(w_a) >  $signed(w_b)};
          FC_SLE:          w_res = {31'd0, $signed(w_a) <= $signed(w_b)};
          FC_SGE:          w_res = {31'd0, $signed(w_a) >= $signed(w_b)};
          default:         w_res = w_a + w_imm;
        endcase
      end
      OP_ADDI, OP_ADDUI: w_res = w_a + w_imm;
      OP_SUBI:           w_res = w_a - w_imm;
      OP_ANDI:           w_res = w_a & w_imm;
      OP_ORI:            w_res = w_a | w_imm;
      OP_XORI:           w_res = w_a ^ w_imm;
      OP_LHI:            w_res = {w_imm[15:0], 16'd0};
      OP_BEQZ: begin
        w_res  = w_npc + w_imm;
        w_cond = (w_a == 32'd0);
      end
      OP_BNEZ: begin
        w_res  = w_npc + w_imm;
        w_cond = (w_a != 32'd0);
      end
      6'b10????:         w_res = w_a + w_imm;
      default:           w_res = w_a + w_imm;
    endcase
  end

  // One multiply/divide step, evaluated from the current iteration registers.
  logic [31:0] w_mul_acc;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_md_result;

  assign w_mul_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh  = {r_acc, r_mplier[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_mcand});
  assign w_rem_nx  = w_ge ? 32'(w_rem_sh - {1'b0, r_mcand}) : w_rem_sh[31:0];
  assign w_quo_nx  = {r_mplier[30:0], w_ge};
  // A zero divisor still runs every iteration; only the delivered value is replaced.
  assign w_md_result = (r_state == S_MUL) ? w_mul_acc :
                       ((r_mcand == 32'd0) ? DIVZ_RESULT : w_quo_nx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_alu    <= 32'd0;
      r_mdr    <= 32'd0;
      r_cond   <= 1'b0;
      r_op     <= 6'd0;
      r_fc     <= 6'd0;
      r_dreg   <= 5'd0;
      r_stall  <= 1'b1;
      r_hold   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.stall_in) begin
            r_stall <= 1'b1;
            r_cond  <= 1'b0;
          end else if (w_is_md) begin
            r_state <= (w_fc == FC_MULT) ? S_MUL : S_DIV;
            r_cnt   <= 6'd0;
            r_acc   <= 32'd0;
            r_mcand <= (w_fc == FC_MULT) ? w_a : w_b;
            r_mplier <= (w_fc == FC_MULT) ? w_b : w_a;
            r_mdr   <= w_b;
            r_cond  <= 1'b0;
            r_op    <= w_op;
            r_fc    <= w_fc;
            r_dreg  <= bus.dreg_in;
            r_stall <= 1'b1;
            r_hold  <= 1'b1;
          end else begin
            r_alu   <= w_res;
            r_mdr   <= w_b;
            r_cond  <= w_cond;
            r_op    <= w_op;
            r_fc    <= w_fc;
            r_dreg  <= bus.dreg_in;
            r_stall <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_state == S_MUL) begin
            r_acc    <= w_mul_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else begin
            r_acc    <= w_rem_nx;
            r_mplier <= w_quo_nx;
          end
          if (r_cnt == 6'(MD_ITERS - 1)) begin
            r_alu   <= w_md_result;
            r_stall <= 1'b0;
            r_hold  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_data_out = r_alu;
  assign bus.mdr_out      = r_mdr;
  assign bus.cond_out     = r_cond;
  assign bus.op_out       = r_op;
  assign bus.fc_out       = r_fc;
  assign bus.dreg_out     = r_dreg;
  assign bus.stall_out    = r_stall;
  assign bus.hold_out     = r_hold;
  assign o_dbg_state      = r_state;

endmodule
